// File: rtl/seq_booth_mult.sv
// Radix-4 Booth sequential multiplier with signed/unsigned mode and valid/ready handshakes.
// Retires two multiplier bits per cycle; product held stable until the next result lands.
module seq_booth_mult #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 is_signed,
  output logic                 dst_valid,
  input  logic                 dst_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned N  = WIDTH / 2 + 1;
  localparam int unsigned AW = 2 * WIDTH + 2;
  localparam int unsigned BW = WIDTH + 3;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [AW-1:0]        m_q, m_d;
  logic [BW-1:0]        b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 src_ready_q, src_ready_d;
  logic                 dst_valid_q, dst_valid_d;
  logic                 busy_q, busy_d;
  logic [AW-1:0]        addend;
  logic                 a_ext, b_ext;

  // b_q keeps the implicit b[-1]=0 in bit 0, so the current digit is always b_q[2:0];
  // m_q is pre-shifted by 2i, so the addend never needs a variable shift.
  always_comb begin
    case (b_q[2:0])
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m_q << 1;
      3'b100:         addend = -(m_q << 1);
      3'b101, 3'b110: addend = -m_q;
      default:        addend = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    m_d         = m_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    src_ready_d = src_ready_q;
    dst_valid_d = dst_valid_q;
    busy_d      = busy_q;
    a_ext       = is_signed & multiplicand[WIDTH-1];
    b_ext       = is_signed & multiplier[WIDTH-1];

    case (state_q)
      S_IDLE: begin
        if (src_valid) begin
          m_d         = {{(AW-WIDTH){a_ext}}, multiplicand};
          b_d         = {{2{b_ext}}, multiplier, 1'b0};
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = S_CALC;
          src_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_CALC: begin
        acc_d = acc_q + addend;
        m_d   = m_q << 2;
        b_d   = b_q >> 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d     = S_DONE;
          product_d   = acc_d[2*WIDTH-1:0];
          dst_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (dst_ready) begin
          state_d     = S_IDLE;
          dst_valid_d = 1'b0;
          src_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        src_ready_d = 1'b1;
        dst_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      m_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      src_ready_q <= 1'b1;
      dst_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      m_q         <= m_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      src_ready_q <= src_ready_d;
      dst_valid_q <= dst_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    src_ready = src_ready_q;
    dst_valid = dst_valid_q;
    product   = product_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Scoreboard bench for seq_booth_mult: driver pushes expected products, a monitor
// pops and checks them together with latency, hold-under-backpressure and exclusivity.
module tb_seq_booth_mult;

  localparam int unsigned W = 16;
  localparam int unsigned N = W / 2 + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             src_valid = 1'b0;
  logic             src_ready;
  logic [W-1:0]     multiplicand = '0;
  logic [W-1:0]     multiplier = '0;
  logic             is_signed = 1'b0;
  logic             dst_valid;
  logic             dst_ready = 1'b0;
  logic [2*W-1:0]   product;
  logic             busy;

  always #5 clk = ~clk;

  seq_booth_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .multiplicand(multiplicand), .multiplier(multiplier), .is_signed(is_signed),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .product(product), .busy(busy)
  );

  typedef struct {
    logic [2*W-1:0] prod;
    int unsigned    k;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int unsigned  edge_cnt = 0;
  int unsigned  prev_k = 0;
  bit           have_prev = 0;
  bit           holding = 0;
  bit           expect_release = 0;
  bit           rand_ready = 0;
  int           bp_cycles = 0;
  logic [2*W-1:0] held;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    longint sx, sy, p;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    p  = sx * sy;
    return p[2*W-1:0];
  endfunction

  // Monitor: samples on the falling edge, then chooses dst_ready for the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      holding        = 0;
      expect_release = 0;
      dst_ready      = 1'b0;
    end else begin
      if (expect_release) begin
        check("release_dst_valid", 64'(dst_valid), 64'd0);
        check("release_src_ready", 64'(src_ready), 64'd1);
        expect_release = 0;
      end
      if (dst_valid) begin
        check("exclusive_src_ready", 64'(src_ready), 64'd0);
        check("busy_in_done", 64'(busy), 64'd1);
        if (!holding) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got product %0h with nothing outstanding", product);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", 64'(product), 64'(e.prod));
            check("latency", 64'(edge_cnt - e.k), 64'(N));
          end
          holding = 1;
          held    = product;
        end else begin
          check("hold_product", 64'(product), 64'(held));
        end
      end
      if (bp_cycles > 0) begin
        dst_ready = 1'b0;
        if (dst_valid) bp_cycles--;
      end else begin
        dst_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (dst_valid && dst_ready) begin
        expect_release = 1;
        holding        = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2*W-1:0] exp_p, input bit expect_res, input bit abuse);
    int unsigned wait_n;
    int unsigned k;
    wait_n = 0;
    @(negedge clk);
    src_valid    = 1'b1;
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    while (!src_ready) begin
      @(negedge clk);
      wait_n++;
      if (wait_n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: src_ready stayed 0 for %0d cycles", wait_n);
        src_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    k = edge_cnt;
    check("accept_src_ready", 64'(src_ready), 64'd0);
    check("accept_busy", 64'(busy), 64'd1);
    if (have_prev) check("init_interval_ok", 64'(k - prev_k >= N + 2), 64'd1);
    prev_k    = k;
    have_prev = 1;
    if (expect_res) sb.push_back('{exp_p, k});
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    is_signed    = ~s;
    if (abuse) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        is_signed    = 1'($urandom);
      end
    end
    src_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || dst_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, dst_valid=%0b", sb.size(), dst_valid);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_dst_valid", 64'(dst_valid), 64'd0);
      check("rst_product", 64'(product), 64'd0);
      check("rst_src_ready", 64'(src_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
    end
    rst = 1'b1;

    rand_ready = 0;
    issue(16'd10,    16'd1,    1'b1, 32'd10,         1, 0);
    issue(16'd10,    16'hFFFF, 1'b1, 32'hFFFF_FFF6,  1, 0);
    issue(16'hFFF6,  16'hFFFF, 1'b1, 32'd10,         1, 0);
    issue(16'd0,     16'hFFFF, 1'b1, 32'd0,          1, 0);
    issue(16'hFF9C,  16'hFC17, 1'b1, 32'd100100,     1, 0);
    issue(16'h8000,  16'h8000, 1'b1, 32'h4000_0000,  1, 0);
    issue(16'h8000,  16'h7FFF, 1'b1, 32'hC000_8000,  1, 0);
    issue(16'hFFFF,  16'hFFFF, 1'b0, 32'hFFFE_0001,  1, 0);
    issue(16'hFFFF,  16'd1,    1'b0, 32'h0000_FFFF,  1, 0);
    issue(16'hFFFF,  16'd1,    1'b1, 32'hFFFF_FFFF,  1, 0);
    issue(16'h8000,  16'd2,    1'b0, 32'h0001_0000,  1, 0);
    issue(16'd1234,  16'd5678, 1'b1, 32'd7006652,    1, 1);
    issue(16'hFFFF,  16'h0003, 1'b0, 32'h0002_FFFD,  1, 1);
    drain();

    bp_cycles = 20;
    issue(16'hFFF0, 16'd3, 1'b1, 32'hFFFF_FFD0, 1, 0);
    drain();

    issue(16'd5, 16'd7, 1'b1, 32'd35, 0, 0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_dst_valid", 64'(dst_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_src_ready", 64'(src_ready), 64'd1);
    check("abort_product", 64'(product), 64'd0);
    repeat (3) @(negedge clk);
    rst       = 1'b1;
    have_prev = 0;
    repeat (15) @(negedge clk);

    rand_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ra = (i % 2 == 0) ? 16'h8000 : 16'hFFFF;
      issue(ra, rb, rs, model(ra, rb, rs), 1, $urandom_range(0, 7) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
